// File: rtl/fetch_unit_pkg.sv
// Shared ISA header for the fetch stage: opcodes, NOP encoding, FSM states and IF/ID payload.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned OPW  = 5;

  localparam logic [OPW-1:0]  OP_HALT           = 5'b00000;
  localparam logic [OPW-1:0]  OP_NOP            = 5'b00001;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = {OP_NOP, 11'h000};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FULL,
    ST_DRAIN,
    ST_HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc2;
  } ifid_entry_t;

  function automatic logic is_halt(input logic [XLEN-1:0] instr);
    return instr[XLEN-1 -: OPW] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_unit_skid.sv
// One-entry holding register for a fetched instruction that decode could not yet accept.
module fetch_skid_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  ifid_entry_t entry_i,
  output ifid_entry_t entry_o,
  output logic        full_o
);

  ifid_entry_t entry_q;
  logic        full_q;

  // Clear wins over load so a redirect always empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      full_q  <= 1'b0;
    end else if (clear_i) begin
      full_q  <= 1'b0;
    end else if (load_i) begin
      entry_q <= entry_i;
      full_q  <= 1'b1;
    end
  end

  assign entry_o = entry_q;
  assign full_o  = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, sequences multi-cycle imem reads and drives the IF/ID
// register, absorbing decode back-pressure with a skid entry and flushing on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc2,
  output logic        if_valid,
  output logic        fetch_busy,
  output logic        err
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  ifid_entry_t     ifid_q, ifid_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            imem_rd_q;
  logic            busy_q;

  logic            skid_load, skid_clear, skid_full;
  ifid_entry_t     skid_entry;

  logic            consume, writable;
  logic [XLEN-1:0] pc_plus2;

  assign consume  = valid_q && !stall_id;
  assign writable = !valid_q || !stall_id;
  assign pc_plus2 = pc_q + XLEN'(2);

  fetch_skid_reg u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .entry_i ({imem_data, pc_plus2}),
    .entry_o (skid_entry),
    .full_o  (skid_full)
  );

  // Next-state, PC and IF/ID update; redirect overrides everything else.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_d     = ifid_q;
    valid_d    = valid_q;
    err_d      = err_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (consume) begin
      valid_d      = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end

    if (redirect) begin
      pc_d         = {redirect_pc[15:1], 1'b0};
      ifid_d.instr = NOP_INSTR;
      valid_d      = 1'b0;
      skid_clear   = 1'b1;
      if (redirect_pc[0]) err_d = 1'b1;
      if (state_q == ST_REQ ||
          ((state_q == ST_WAIT || state_q == ST_DRAIN) && !imem_done)) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ:  state_d = ST_WAIT;
        ST_WAIT: begin
          if (imem_done) begin
            pc_d = pc_plus2;
            if (writable) begin
              ifid_d  = {imem_data, pc_plus2};
              valid_d = 1'b1;
              state_d = is_halt(imem_data) ? ST_HALTED : ST_REQ;
            end else begin
              skid_load = 1'b1;
              state_d   = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (consume && skid_full) begin
            ifid_d     = skid_entry;
            valid_d    = 1'b1;
            skid_clear = 1'b1;
            state_d    = is_halt(skid_entry.instr) ? ST_HALTED : ST_REQ;
          end
        end
        ST_DRAIN:  if (imem_done) state_d = ST_REQ;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Moore outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ifid_q    <= {NOP_INSTR, 16'h0000};
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      imem_rd_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ifid_q    <= ifid_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      imem_rd_q <= (state_d == ST_REQ);
      busy_q    <= (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_DRAIN);
    end
  end

  assign imem_rd    = imem_rd_q;
  assign imem_addr  = pc_q;
  assign if_instr   = ifid_q.instr;
  assign if_pc2     = ifid_q.pc2;
  assign if_valid   = valid_q;
  assign fetch_busy = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: program-order reference stream, latency-randomised memory,
// directed scenarios followed by random stall/redirect traffic.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        stall_id;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] if_instr;
  logic [15:0] if_pc2;
  logic        if_valid;
  logic        fetch_busy;
  logic        err;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_done   (imem_done),
    .stall_id    (stall_id),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_instr    (if_instr),
    .if_pc2      (if_pc2),
    .if_valid    (if_valid),
    .fetch_busy  (fetch_busy),
    .err         (err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory image: HALT at 0x0010 and at every xxBE, pseudo-random elsewhere.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] h;
    if (a == 16'h0010 || a[7:0] == 8'hBE) return 16'h0000;
    h = (a ^ 16'hA5C3) * 16'h6F4B + 16'h1235;
    if (h[15:11] == 5'b00000) h[15:11] = 5'b10101;
    return h;
  endfunction

  // Expected delivery stream: program order from the current start PC up to the first HALT.
  ifid_entry_t exp_q[$];
  logic [15:0] pc2_log[$];
  logic [15:0] req_log[$];
  bit          model_halted = 1'b0;
  logic        exp_err = 1'b0;

  function automatic void refill(input logic [15:0] target);
    logic [15:0] a;
    logic [15:0] w;
    ifid_entry_t e;
    exp_q.delete();
    a = target;
    for (int i = 0; i < 300; i++) begin
      w = mem_word(a);
      e.instr = w;
      e.pc2   = a + 16'd2;
      exp_q.push_back(e);
      if (w[15:11] == OP_HALT) break;
      a = a + 16'd2;
    end
  endfunction

  // Memory responder: single outstanding read, answers lat cycles after imem_rd.
  int          lat = 1;
  bit          pending = 1'b0;
  int          cnt = 0;
  logic [15:0] pend_addr = 16'h0;
  bit          inject_stray = 1'b0;

  initial begin
    imem_done = 1'b0;
    imem_data = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_done = 1'b0;
      imem_data = 16'($urandom);
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            imem_done = 1'b1;
            imem_data = mem_word(pend_addr);
            pending   = 1'b0;
          end
        end
        if (inject_stray) begin
          imem_done    = 1'b1;
          imem_data    = 16'h0000;
          inject_stray = 1'b0;
        end
        if (imem_rd) begin
          check16("no_overlapping_request", 16'(pending), 16'd0);
          pending   = 1'b1;
          cnt       = lat;
          pend_addr = imem_addr;
          req_log.push_back(imem_addr);
        end
      end
    end
  end

  // Monitor: compares every consumed IF/ID entry and the sticky/empty/halt invariants.
  initial begin
    ifid_entry_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        refill(16'h0000);
        model_halted = 1'b0;
        exp_err      = 1'b0;
      end else begin
        check16("err", 16'(err), 16'(exp_err));
        if (!if_valid) check16("empty_ifid_nop", if_instr, 16'h0800);
        if (model_halted) check16("halted_no_rd", 16'(imem_rd), 16'd0);
        if (if_valid && !stall_id) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL delivery: got instr %h pc2 %h expected nothing", if_instr, if_pc2);
          end else begin
            e = exp_q.pop_front();
            check16("if_instr", if_instr, e.instr);
            check16("if_pc2", if_pc2, e.pc2);
            if (e.instr[15:11] == OP_HALT) model_halted = 1'b1;
          end
          pc2_log.push_back(if_pc2);
        end
        if (redirect) begin
          refill({redirect_pc[15:1], 1'b0});
          model_halted = 1'b0;
          if (redirect_pc[0]) exp_err = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input int n, input string name);
    int k = 0;
    while (req_log.size() < n && k < 200) begin cyc(); k++; end
    tests++;
    if (req_log.size() < n) begin
      fails++;
      $display("FAIL %s: got %0d requests expected %0d", name, req_log.size(), n);
    end
  endtask

  task automatic wait_cons(input int n, input string name);
    int k = 0;
    while (pc2_log.size() < n && k < 300) begin cyc(); k++; end
    tests++;
    if (pc2_log.size() < n) begin
      fails++;
      $display("FAIL %s: got %0d deliveries expected %0d", name, pc2_log.size(), n);
    end
  endtask

  task automatic wait_rd(input string name);
    int k = 0;
    while (!imem_rd && k < 200) begin cyc(); k++; end
    tests++;
    if (!imem_rd) begin
      fails++;
      $display("FAIL %s: got imem_rd 0 expected 1", name);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check16({tag, "_imem_rd"}, 16'(imem_rd), 16'd0);
    check16({tag, "_imem_addr"}, imem_addr, 16'h0000);
    check16({tag, "_if_instr"}, if_instr, 16'h0800);
    check16({tag, "_if_pc2"}, if_pc2, 16'h0000);
    check16({tag, "_if_valid"}, 16'(if_valid), 16'd0);
    check16({tag, "_fetch_busy"}, 16'(fetch_busy), 16'd0);
    check16({tag, "_err"}, 16'(err), 16'd0);
  endtask

  task automatic do_redirect(input logic [15:0] target, output int rc, output int cl);
    redirect    = 1'b1;
    redirect_pc = target;
    rc          = req_log.size();
    cyc();
    redirect = 1'b0;
    cl       = pc2_log.size();
  endtask

  initial begin
    int rc, cl, k, start_cons;
    stall_id    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    #1 rst = 1'b1;
    cyc();
    cyc();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Sequential fetch at latency 1.
    wait_req(3, "seq_requests");
    check16("req0", req_log[0], 16'h0000);
    check16("req1", req_log[1], 16'h0002);
    check16("req2", req_log[2], 16'h0004);
    wait_cons(3, "seq_deliveries");
    check16("pc2_0", pc2_log[0], 16'h0002);
    check16("pc2_1", pc2_log[1], 16'h0004);
    check16("pc2_2", pc2_log[2], 16'h0006);

    // Back-pressure fills IF/ID and skid, fetch stops.
    stall_id = 1'b1;
    repeat (8) cyc();
    rc = req_log.size();
    check16("full_no_rd", 16'(imem_rd), 16'd0);
    check16("full_not_busy", 16'(fetch_busy), 16'd0);
    check16("full_if_valid", 16'(if_valid), 16'd1);
    cyc();
    cyc();
    check16("full_no_new_req", 16'(req_log.size()), 16'(rc));
    stall_id = 1'b0;

    // HALT at 0x0010 stops fetch.
    k = 0;
    while (!model_halted && k < 200) begin cyc(); k++; end
    check16("halt_reached", 16'(model_halted), 16'd1);
    check16("halt_pc2", pc2_log[pc2_log.size()-1], 16'h0012);
    rc = req_log.size();
    repeat (10) cyc();
    check16("halt_no_req", 16'(req_log.size()), 16'(rc));

    // Redirect out of HALTED.
    do_redirect(16'h0020, rc, cl);
    wait_req(rc + 1, "resume_req");
    check16("resume_addr", req_log[rc], 16'h0020);

    // Redirect while WAIT: response is drained.
    lat = 3;
    cyc();
    wait_rd("rd_before_wait_redirect");
    cyc();
    do_redirect(16'h0040, rc, cl);
    check16("flush_if_valid", 16'(if_valid), 16'd0);
    check16("flush_if_instr", if_instr, 16'h0800);
    check16("drain_busy", 16'(fetch_busy), 16'd1);
    wait_req(rc + 1, "drain_req");
    check16("drain_addr", req_log[rc], 16'h0040);

    // PC wrap at 0xFFFE.
    lat = 1;
    do_redirect(16'hFFFE, rc, cl);
    wait_req(rc + 2, "wrap_req");
    check16("wrap_addr0", req_log[rc], 16'hFFFE);
    check16("wrap_addr1", req_log[rc+1], 16'h0000);
    wait_cons(cl + 1, "wrap_deliver");
    check16("wrap_pc2", pc2_log[cl], 16'h0000);

    // Odd redirect target sets sticky err.
    do_redirect(16'h0033, rc, cl);
    check16("odd_err", 16'(err), 16'd1);
    wait_req(rc + 1, "odd_req");
    check16("odd_addr", req_log[rc], 16'h0032);

    // Reset during WAIT, stray done afterwards.
    lat = 3;
    cyc();
    wait_rd("rd_before_reset");
    cyc();
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    cyc();
    cyc();
    rst          = 1'b0;
    lat          = 1;
    inject_stray = 1'b1;
    rc           = req_log.size();
    cl           = pc2_log.size();
    wait_req(rc + 1, "post_reset_req");
    check16("post_reset_addr", req_log[rc], 16'h0000);
    wait_cons(cl + 2, "post_reset_deliver");
    check16("post_reset_pc2", pc2_log[cl], 16'h0002);

    // Random stall/latency/redirect traffic against the scoreboard.
    start_cons = pc2_log.size();
    for (int i = 0; i < 3000; i++) begin
      stall_id = ($urandom % 100) < 30;
      lat      = 1 + int'($urandom % 4);
      redirect = ($urandom % 100) < 3;
      if ($urandom % 8 == 0) redirect_pc = 16'hFFF0 | 16'($urandom_range(0, 15));
      else                   redirect_pc = 16'($urandom_range(0, 511));
      cyc();
    end
    stall_id = 1'b0;
    redirect = 1'b0;
    repeat (20) cyc();
    check16("random_progress", 16'(pc2_log.size() - start_cons > 100), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
